// File: rtl/drp_pkg.sv
// Shared types, widths and helpers for the multi-port DRP access engine.
package drp_pkg;

  localparam int DRP_ADDR_W = 10;
  localparam int DRP_DATA_W = 16;

  // Engine FSM states; exported on the debug port for observation.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_EN   = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_EN   = 3'd3,
    S_WR_WAIT = 3'd4,
    S_RESP    = 3'd5
  } drp_state_e;

  // Read-modify-write merge: bits set in wmask take wdata, the rest keep rdata.
  function automatic logic [DRP_DATA_W-1:0] rmw_merge(
    input logic [DRP_DATA_W-1:0] rdata,
    input logic [DRP_DATA_W-1:0] wdata,
    input logic [DRP_DATA_W-1:0] wmask
  );
    return (rdata & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/drp_multi_master_if.sv
// Request/response bus between the register fabric and the DRP engine.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the requester holds req_* stable while req_valid=1
// and req_ready=0. The engine raises req_ready only when idle, so one access
// is in flight at a time. The response is a single-cycle rsp_valid pulse
// with no backpressure; rsp_rdata and rsp_err are meaningful only with it.
interface drp_multi_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int PORT_W = 1
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [PORT_W-1:0] req_port;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_port, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_port, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/drp_timeout_ctr.sv
// Saturating wait-cycle counter; expired_o flags the last allowed wait cycle.
module drp_timeout_ctr #(
  parameter int TIMEOUT = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // TIMEOUT of zero means wait forever.
  assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/drp_multi_master.sv
// DRP access engine: one request bus fanned out to NUM_PORTS DRP ports,
// supporting read, plain write and masked read-modify-write with timeout.
module drp_multi_master
  import drp_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = DRP_ADDR_W,
  parameter int DATA_W    = DRP_DATA_W,
  parameter int TIMEOUT   = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  drp_multi_master_if.slave           bus,
  output logic [NUM_PORTS-1:0]        drp_en,
  output logic [NUM_PORTS-1:0]        drp_we,
  output logic [ADDR_W-1:0]           drp_addr,
  output logic [DATA_W-1:0]           drp_di,
  input  logic [NUM_PORTS*DATA_W-1:0] drp_do,
  input  logic [NUM_PORTS-1:0]        drp_rdy,
  output drp_state_e                  dbg_state
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  drp_state_e state_q, state_d;

  logic [PORT_W-1:0]    port_q;
  logic                 rmw_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    wmask_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    di_q;

  logic                 accept;
  logic                 port_ok;
  logic                 full_mask;
  logic                 in_wait;
  logic                 expired;
  logic                 timeout;
  logic                 sel_rdy;
  logic [DATA_W-1:0]    sel_do;
  logic [NUM_PORTS-1:0] port_oh;
  logic [DATA_W-1:0]    merged;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign port_ok   = ({1'b0, bus.req_port} < (PORT_W + 1)'(NUM_PORTS));
  assign full_mask = (bus.req_wmask == {DATA_W{1'b1}});
  assign in_wait   = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
  assign timeout   = in_wait && !sel_rdy && expired;
  assign merged    = rmw_merge(sel_do, wdata_q, wmask_q);

  // Select ready, read data and one-hot strobe of the latched port only.
  always_comb begin
    sel_rdy = 1'b0;
    sel_do  = '0;
    port_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_q == PORT_W'(p)) begin
        sel_rdy    = drp_rdy[p];
        sel_do     = drp_do[p*DATA_W +: DATA_W];
        port_oh[p] = 1'b1;
      end
    end
  end

  // One counter serves both wait states; it is held clear everywhere else.
  drp_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_wait),
    .en_i     (in_wait && !sel_rdy),
    .expired_o(expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!port_ok) begin
            state_d = S_RESP;
          end else if (!bus.req_we || !full_mask) begin
            state_d = S_RD_EN;
          end else begin
            state_d = S_WR_EN;
          end
        end
      end
      S_RD_EN:   state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (sel_rdy) begin
          state_d = rmw_q ? S_WR_EN : S_RESP;
        end else if (expired) begin
          state_d = S_RESP;
        end
      end
      S_WR_EN:   state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (sel_rdy || expired) begin
          state_d = S_RESP;
        end
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request latch, read capture, merge result and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q  <= '0;
      rmw_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
    end else begin
      if (accept) begin
        port_q  <= bus.req_port;
        rmw_q   <= bus.req_we && !full_mask;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
        rdata_q <= '0;
        err_q   <= !port_ok;
        // Bad-port requests leave the DRP bus untouched.
        if (port_ok) begin
          addr_q <= bus.req_addr;
          if (bus.req_we && full_mask) begin
            di_q <= bus.req_wdata;
          end
        end
      end
      if ((state_q == S_RD_WAIT) && sel_rdy) begin
        rdata_q <= sel_do;
        if (rmw_q) begin
          di_q <= merged;
        end
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    drp_en        = '0;
    drp_we        = '0;
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    if ((state_q == S_RD_EN) || (state_q == S_WR_EN)) begin
      drp_en = port_oh;
    end
    if (state_q == S_WR_EN) begin
      drp_we = port_oh;
    end
    if (state_q == S_RESP) begin
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
    end
  end

  assign drp_addr  = addr_q;
  assign drp_di    = di_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_drp_multi_master.sv
// Directed bench for drp_multi_master: vector table plus reset/late-ready sequences.
module tb_drp_multi_master;
  import drp_pkg::*;

  localparam int NP = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 50;
  localparam int PW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drp_multi_master_if #(.ADDR_W(AW), .DATA_W(DW), .PORT_W(PW)) bus ();

  logic [NP-1:0]    drp_en;
  logic [NP-1:0]    drp_we;
  logic [NP-1:0]    drp_rdy;
  logic [AW-1:0]    drp_addr;
  logic [DW-1:0]    drp_di;
  logic [NP*DW-1:0] drp_do;
  drp_state_e       dbg_state;

  drp_multi_master #(
    .NUM_PORTS(NP),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drp_en   (drp_en),
    .drp_we   (drp_we),
    .drp_addr (drp_addr),
    .drp_di   (drp_di),
    .drp_do   (drp_do),
    .drp_rdy  (drp_rdy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input logic [PW-1:0] p);
    logic [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      if (PW'(i) == p) r[i] = 1'b1;
    end
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [PW-1:0] port;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] do_val;
    int            k_rd;    // rdy delay after read en, 0 = never
    int            k_wr;    // rdy delay after write en, 0 = never
    int            exp_lat; // cycles from accept edge to rsp_valid
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_en;
    int            exp_we;
    logic [DW-1:0] exp_di;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [PW-1:0] port, input logic [AW-1:0] addr,
    input logic [DW-1:0] wdata, input logic [DW-1:0] wmask, input logic [DW-1:0] do_val,
    input int k_rd, input int k_wr, input int lat, input logic [DW-1:0] rdata,
    input logic err, input int en_n, input int we_n, input logic [DW-1:0] di
  );
    vec_t v;
    v.we = we; v.port = port; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.do_val = do_val; v.k_rd = k_rd; v.k_wr = k_wr; v.exp_lat = lat;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_en = en_n; v.exp_we = we_n; v.exp_di = di;
    return v;
  endfunction

  vec_t vecs[10];

  // ---------------- driver ----------------
  task automatic set_do(input logic [PW-1:0] port, input logic [DW-1:0] val);
    for (int p = 0; p < NP; p++) begin
      drp_do[p*DW +: DW] = (PW'(p) == port) ? val : (DW'(16'hD000) + DW'(p));
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_port  = v.port;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wmask = v.wmask;
  endtask

  task automatic run_vec(input vec_t v);
    int rd_t, wr_t, en_cnt, we_cnt, lat;
    logic got;
    logic [DW-1:0] di_seen;
    logic [AW-1:0] addr_seen;
    logic [NP-1:0] sel;
    logic [DW-1:0] exp_d;
    rd_t = -1; wr_t = -1; en_cnt = 0; we_cnt = 0; lat = 0; got = 1'b0;
    di_seen = '0; addr_seen = '0;
    sel = oh(v.port);
    set_do(v.port, v.do_val);
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    drive_req(v);
    exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    for (int c = 1; c <= 120 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
      end
      if (drp_en != '0) begin
        en_cnt++;
        addr_seen = drp_addr;
        check("en_onehot", 32'(drp_en), 32'(sel));
        if (drp_we != '0) begin
          we_cnt++;
          di_seen = drp_di;
          check("we_matches_en", 32'(drp_we), 32'(drp_en));
          wr_t = (v.k_wr > 0) ? c + v.k_wr : -1;
        end else begin
          rd_t = (v.k_rd > 0) ? c + v.k_rd : -1;
        end
      end else if (drp_we != '0) begin
        check("we_without_en", 32'(drp_we), 32'd0);
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = c;
        exp_d = exp_q.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_d));
        check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
      end
      // Other ports always show ready as noise; the target only at its slot.
      drp_rdy = (~sel) | (((c == rd_t) || (c == wr_t)) ? sel : '0);
    end
    drp_rdy = '0;
    if (!got) begin
      void'(exp_q.pop_front());
      check("rsp_seen_in_budget", 32'd0, 32'd1);
    end else begin
      check("rsp_latency", 32'(lat), 32'(v.exp_lat));
    end
    check("en_count", 32'(en_cnt), 32'(v.exp_en));
    check("we_count", 32'(we_cnt), 32'(v.exp_we));
    if (en_cnt > 0) check("drp_addr", 32'(addr_seen), 32'(v.addr));
    if (we_cnt > 0) check("drp_di", 32'(di_seen), 32'(v.exp_di));
    @(negedge clk);
    check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
    check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    //            we port addr    wdata    wmask    do_val  krd kwr lat rdata    err en we di
    vecs[0] = mk(0, 1, 10'h05F, 16'h0000, 16'hFFFF, 16'hA5C3, 3, 0,  5, 16'hA5C3, 0, 1, 0, 16'h0000);
    vecs[1] = mk(1, 0, 10'h011, 16'h1234, 16'hFFFF, 16'h9999, 0, 1,  3, 16'h0000, 0, 1, 1, 16'h1234);
    vecs[2] = mk(1, 0, 10'h020, 16'h00AA, 16'h00FF, 16'hFF00, 2, 2,  7, 16'hFF00, 0, 2, 1, 16'hFFAA);
    vecs[3] = mk(0, 3, 10'h055, 16'h0000, 16'hFFFF, 16'h1111, 1, 1,  1, 16'h0000, 1, 0, 0, 16'h0000);
    vecs[4] = mk(0, 2, 10'h3FF, 16'h0000, 16'hFFFF, 16'h0F0F, 1, 0,  3, 16'h0F0F, 0, 1, 0, 16'h0000);
    vecs[5] = mk(1, 2, 10'h0C0, 16'hFFFF, 16'h0F0F, 16'h1234, 1, 1,  5, 16'h1234, 0, 2, 1, 16'h1F3F);
    vecs[6] = mk(0, 0, 10'h001, 16'h5A5A, 16'h00F0, 16'hBEEF, 2, 0,  4, 16'hBEEF, 0, 1, 0, 16'h0000);
    vecs[7] = mk(1, 1, 10'h2A0, 16'hAAAA, 16'h0000, 16'h5555, 1, 1,  5, 16'h5555, 0, 2, 1, 16'h5555);
    vecs[8] = mk(0, 1, 10'h100, 16'h0000, 16'hFFFF, 16'h7777, 0, 0, 52, 16'h0000, 1, 1, 0, 16'h0000);
    vecs[9] = mk(1, 0, 10'h101, 16'h0003, 16'h000F, 16'h00FF, 1, 0, 54, 16'h00FF, 1, 2, 1, 16'h00F3);

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_port = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0;
    drp_rdy = '0; drp_do = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_drp_en", 32'(drp_en), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_drp_addr", 32'(drp_addr), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      if (i == 8) begin
        // Late ready after the read timeout must be dropped.
        repeat (3) @(negedge clk);
        drp_rdy = 3'b010;
        @(negedge clk);
        drp_rdy = '0;
        check("late_rdy_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("late_rdy_ready", 32'(bus.req_ready), 32'd1);
        check("late_rdy_no_en", 32'(drp_en), 32'd0);
        @(negedge clk);
        check("late_rdy_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        run_vec(vecs[0]);
      end
    end

    // Reset in the middle of a read wait.
    set_do(2'd1, 16'h4321);
    @(negedge clk);
    drive_req(mk(0, 1, 10'h2AA, 16'h0, 16'hFFFF, 16'h4321, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_rst_en", 32'(drp_en), 32'b010);
    check("mid_rst_addr", 32'(drp_addr), 32'h2AA);
    @(negedge clk);
    check("mid_rst_state", 32'(dbg_state), 32'(S_RD_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cleared_en", 32'(drp_en), 32'd0);
    check("mid_rst_cleared_we", 32'(drp_we), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_addr0", 32'(drp_addr), 32'd0);
    check("mid_rst_di0", 32'(drp_di), 32'd0);
    check("mid_rst_state_idle", 32'(dbg_state), 32'(S_IDLE));
    drp_rdy = 3'b010;
    @(negedge clk);
    drp_rdy = '0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
    end
    run_vec(vecs[4]);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drp_multi_master.md
Name: drp_multi_master

Overview:
- Parametrised DRP access engine serving NUM_PORTS transceiver/clocking DRP ports from a single request/response interface.
- Supports reads, full writes and masked read-modify-write (RMW), with a per-access ready timeout and error reporting.
- Sits between the control/register fabric and the DRP ports of the PRBS/LED link hardware. Replaces free-running single-port polling with on-demand transactions.

Parameters:
- NUM_PORTS, 2, number of DRP ports served (>=1)
- ADDR_W, 10, DRP address width
- DATA_W, 16, DRP data width
- TIMEOUT, 50, maximum wait cycles for drp_rdy per access; 0 disables timeout
- PORT_W, max(1,clog2(NUM_PORTS)), port-select width (derived)

Ports:
- clk  in  1  DRP clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  engine idle, request accepted on valid&ready
- req_we  in  1  1=write, 0=read
- req_port  in  PORT_W  target port index
- req_addr  in  ADDR_W  DRP address
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W  bit write-enable; all-ones = plain write, else RMW
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data (RMW: original value before modification)
- rsp_err  out  1  timeout or bad port, qualified by rsp_valid
- busy  out  1  inverse of req_ready
- drp_en  out  NUM_PORTS  one-hot enable, one cycle per access
- drp_we  out  NUM_PORTS  one-hot write strobe, coincident with drp_en
- drp_addr  out  ADDR_W  shared address
- drp_di  out  DATA_W  shared write data
- drp_do  in  NUM_PORTS*DATA_W  port p read data at bits [p*DATA_W +: DATA_W]
- drp_rdy  in  NUM_PORTS  per-port ready

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. On rst, the next edge clears every output to 0, req_ready excepted (req_ready=1, busy=0), and the FSM goes to IDLE. Reset mid-access drops drp_en/drp_we immediately. A subsequent drp_rdy is ignored.
- States: IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch port, addr, we, wdata and wmask.
  - If port >= NUM_PORTS, go to RESP with err=1 and no DRP activity.
  - Read or RMW goes to RD_EN. Plain write goes to WR_EN.
- RD_EN: drp_en[port]=1, drp_we=0, drp_addr=addr for exactly one cycle, then RD_WAIT with the timeout counter cleared.
- RD_WAIT:
  - drp_rdy[port] is sampled from the cycle after drp_en.
  - On rdy, capture drp_do slice into rdata.
    - Read: go to RESP.
    - RMW: compute merged = (rdata & ~wmask) | (wdata & wmask), then go to WR_EN.
  - Otherwise increment the counter. When TIMEOUT!=0 and counter==TIMEOUT-1 without rdy, go to RESP with err=1 and rdata=0.
- WR_EN: drp_en[port]=drp_we[port]=1, drp_di = wdata (plain) or merged (RMW) for one cycle, then WR_WAIT with the counter cleared.
- WR_WAIT: same rdy/timeout rules as RD_WAIT. On rdy go to RESP. On timeout go to RESP with err=1; rdata keeps the RMW read value (0 for a plain write).
- RESP: rsp_valid=1 for one cycle with rsp_rdata and rsp_err, then IDLE.
- Latency:
  - Read with rdy k>=1 cycles after en: accept at edge T0, en in cycle T0+1, rsp_valid in cycle T0+k+2, req_ready high in T0+k+3.
  - RMW adds write en and wait.
- drp_rdy on non-selected ports is ignored, as is rdy while in IDLE/EN/RESP (late rdy after timeout is dropped).
- drp_addr/drp_di hold their last value between accesses. drp_en/drp_we are 0 outside the *_EN states.
- Counter width: clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package drp_pkg: FSM state enum, DRP_ADDR_W=10 and DRP_DATA_W=16 constants, rmw_merge function.
- One natural sub-module: drp_timeout_ctr (clear, enable, expired output, TIMEOUT parameter), reused for both wait states.

Test Plan:
- Read port 1, addr 0x05F, drp_do[1]=0xA5C3, rdy 3 cycles after en:
  - drp_en=2'b10 for 1 cycle, drp_we=0.
  - rsp_valid 5 cycles after accept, rdata=0xA5C3, err=0.
- Plain write port 0, addr 0x011, wdata=0x1234, wmask=0xFFFF, rdy after 1 cycle:
  - single en+we on port 0, drp_di=0x1234, no read phase, err=0.
- RMW port 0, original 0xFF00, wdata=0x00AA, wmask=0x00FF:
  - read phase, then write with drp_di=0xFFAA.
  - rsp_rdata=0xFF00.
- Timeout with TIMEOUT=50, rdy never asserted:
  - rsp_valid after 50 wait cycles, err=1, rdata=0.
  - rdy pulsed 5 cycles later is ignored and the next request is served normally.
- Bad port (NUM_PORTS=3, req_port=3):
  - no drp_en, rsp_valid 1 cycle after accept, err=1.
- rst asserted in RD_WAIT: outputs cleared on the next edge, no rsp_valid, late rdy ignored, req_ready=1.
